// File: rtl/div_unit.sv
// div_unit -- multicycle signed divider (MIPS DIV semantics).
// Restoring division on operand magnitudes, one quotient bit per clock,
// then a single sign-fixup cycle.
//
// Ports:
//   Clk     : clock, all state updates on the rising edge
//   Reset   : synchronous active-high reset, abandons any division in flight
//   Start   : request pulse, only honoured while idle
//   A, B    : dividend / divisor (two's complement), sampled on accepted Start
//   Busy    : high while iterating or fixing signs
//   Done    : one-cycle pulse when Hi/Lo are valid or a divide-by-zero is flagged
//   DivZero : one-cycle pulse coincident with Done when B was zero
//   Hi, Lo  : remainder / quotient, held until the next successful completion
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] remR;     // partial remainder
  logic [WIDTH-1:0] quoQ;     // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] divD;     // divisor magnitude
  logic [CW-1:0]    count;
  logic             sA;       // remainder takes the dividend's sign
  logic             sQ;       // quotient negative when operand signs differ

  logic [WIDTH-1:0] absA, absB;
  logic [WIDTH:0]   rShift, trial;

  // |-2^(W-1)| wraps to 2^(W-1), which is the correct unsigned magnitude.
  assign absA = A[WIDTH-1] ? -A : A;
  assign absB = B[WIDTH-1] ? -B : B;

  // remR < divD <= 2^(W-1), so the shifted remainder never overflows W+1 bits
  // and trial[WIDTH] is a clean borrow/sign bit.
  assign rShift = {remR, quoQ[WIDTH-1]};
  assign trial  = rShift - {1'b0, divD};

  assign Busy = (state == RUN) || (state == FIX);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      remR    <= '0;
      quoQ    <= '0;
      divD    <= '0;
      count   <= '0;
      sA      <= 1'b0;
      sQ      <= 1'b0;
      Done    <= 1'b0;
      DivZero <= 1'b0;
      Hi      <= '0;
      Lo      <= '0;
    end else begin
      Done    <= 1'b0;
      DivZero <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            if (B == '0) begin
              // Report immediately; Hi/Lo keep the last good result.
              Done    <= 1'b1;
              DivZero <= 1'b1;
            end else begin
              quoQ  <= absA;
              divD  <= absB;
              remR  <= '0;
              sA    <= A[WIDTH-1];
              sQ    <= A[WIDTH-1] ^ B[WIDTH-1];
              count <= CW'(WIDTH);
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (!trial[WIDTH]) begin
            remR <= trial[WIDTH-1:0];
            quoQ <= {quoQ[WIDTH-2:0], 1'b1};
          end else begin
            remR <= rShift[WIDTH-1:0];
            quoQ <= {quoQ[WIDTH-2:0], 1'b0};
          end
          count <= count - CW'(1);
          if (count == CW'(1)) state <= FIX;
        end
        FIX: begin
          Lo    <= sQ ? -quoQ : quoQ;
          Hi    <= sA ? -remR : remR;
          Done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit -- self-checking bench for div_unit (WIDTH=32).
// Expected results come from signed 64-bit arithmetic (truncating / and %),
// plus a record of the last good Hi/Lo for divide-by-zero retention.
module tb_div_unit;

  logic        Clk = 1'b0;
  logic        Reset, Start, Busy, Done, DivZero;
  logic [31:0] A, B, Hi, Lo;

  int tests = 0;
  int fails = 0;
  logic [31:0] lastHi = '0, lastLo = '0;

  div_unit #(.WIDTH(32)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .A(A), .B(B),
    .Busy(Busy), .Done(Done), .DivZero(DivZero), .Hi(Hi), .Lo(Lo)
  );

  always #5 Clk = ~Clk;

  function automatic void refDiv(input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] q, output logic [31:0] r);
    longint sa, sb, qq, rr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    qq = sa / sb;
    rr = sa % sb;
    q = qq[31:0];
    r = rr[31:0];
  endfunction

  // Issues one request and watches up to 40 cycles for Done.
  // k counts cycles after the accepting edge (k=0 is the first one).
  task automatic runOp(input logic [31:0] a, input logic [31:0] b,
                       input bit sameCycle, input int rePulseAt,
                       output logic [31:0] hi, output logic [31:0] lo,
                       output int doneAt, output int busyCnt, output logic dz);
    if (!sameCycle) @(negedge Clk);
    Start = 1'b1; A = a; B = b;
    doneAt = -1; busyCnt = 0; dz = 1'b0; hi = 'x; lo = 'x;
    for (int k = 0; k < 40; k++) begin
      @(negedge Clk);
      Start = 1'b0; A = $urandom; B = $urandom;
      if (k == rePulseAt) begin Start = 1'b1; A = 32'd1; B = 32'd1; end
      if (Busy) busyCnt++;
      if (Done) begin
        doneAt = k; hi = Hi; lo = Lo; dz = DivZero;
        break;
      end
    end
  endtask

  task automatic test_reset;
    Reset = 1'b1; Start = 1'b0; A = '0; B = '0;
    repeat (2) @(negedge Clk);
    tests++; if ({Busy, Done, DivZero} !== 3'b000) begin fails++; $display("FAIL reset_flags: got %b expected 000", {Busy, Done, DivZero}); end
    tests++; if ({Hi, Lo} !== 64'd0) begin fails++; $display("FAIL reset_hilo: got %h expected 0", {Hi, Lo}); end
    Reset = 1'b0;
  endtask

  task automatic test_basic;
    logic [31:0] hi, lo; int doneAt, busyCnt; logic dz;
    runOp(32'd7, 32'd2, 1'b0, -1, hi, lo, doneAt, busyCnt, dz);
    tests++; if (doneAt !== 33) begin fails++; $display("FAIL basic_latency: got %0d expected 33", doneAt); end
    tests++; if (busyCnt !== 33) begin fails++; $display("FAIL basic_busy: got %0d expected 33", busyCnt); end
    tests++; if (lo !== 32'd3 || hi !== 32'd1 || dz !== 1'b0) begin fails++; $display("FAIL basic_result: got lo=%h hi=%h dz=%b expected 3 1 0", lo, hi, dz); end
    @(negedge Clk);
    tests++; if (Done !== 1'b0) begin fails++; $display("FAIL basic_done_pulse: got %b expected 0", Done); end
    lastHi = 32'd1; lastLo = 32'd3;
  endtask

  task automatic test_divzero;
    logic [31:0] hi, lo; int doneAt, busyCnt; logic dz;
    runOp(32'd5, 32'd0, 1'b0, -1, hi, lo, doneAt, busyCnt, dz);
    tests++; if (doneAt !== 0 || dz !== 1'b1) begin fails++; $display("FAIL dz_flag: got doneAt=%0d dz=%b expected 0 1", doneAt, dz); end
    tests++; if (busyCnt !== 0) begin fails++; $display("FAIL dz_busy: got %0d expected 0", busyCnt); end
    tests++; if (hi !== lastHi || lo !== lastLo) begin fails++; $display("FAIL dz_retain: got hi=%h lo=%h expected %h %h", hi, lo, lastHi, lastLo); end
    @(negedge Clk);
    tests++; if (Done !== 1'b0 || DivZero !== 1'b0) begin fails++; $display("FAIL dz_pulse: got %b%b expected 00", Done, DivZero); end
  endtask

  task automatic test_signs;
    logic [31:0] ta [5] = '{32'hFFFFFFF9, 32'd7,        32'hFFFFFFF9, 32'h80000000, 32'h80000000};
    logic [31:0] tb [5] = '{32'd2,        32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd1};
    logic [31:0] eq [5] = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'd3,        32'h80000000, 32'h80000000};
    logic [31:0] er [5] = '{32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0,        32'd0};
    logic [31:0] hi, lo; int doneAt, busyCnt; logic dz;
    for (int i = 0; i < 5; i++) begin
      runOp(ta[i], tb[i], 1'b0, -1, hi, lo, doneAt, busyCnt, dz);
      tests++;
      if (doneAt !== 33 || dz !== 1'b0 || lo !== eq[i] || hi !== er[i]) begin
        fails++;
        $display("FAIL sign_%0d: got at=%0d dz=%b lo=%h hi=%h expected 33 0 %h %h", i, doneAt, dz, lo, hi, eq[i], er[i]);
      end
      lastHi = er[i]; lastLo = eq[i];
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] hi, lo; int doneAt, busyCnt; logic dz;
    runOp(32'd100, 32'd7, 1'b0, 10, hi, lo, doneAt, busyCnt, dz);
    tests++; if (doneAt !== 33 || lo !== 32'd14 || hi !== 32'd2) begin fails++; $display("FAIL ignore_start: got at=%0d lo=%h hi=%h expected 33 e 2", doneAt, lo, hi); end
    runOp(32'd9, 32'd3, 1'b1, -1, hi, lo, doneAt, busyCnt, dz);
    tests++; if (doneAt !== 33 || lo !== 32'd3 || hi !== 32'd0) begin fails++; $display("FAIL b2b: got at=%0d lo=%h hi=%h expected 33 3 0", doneAt, lo, hi); end
    lastHi = 32'd0; lastLo = 32'd3;
  endtask

  task automatic test_mid_reset;
    logic [31:0] hi, lo; int doneAt, busyCnt; logic dz; int sawDone;
    runOp(32'd100, 32'd7, 1'b0, -1, hi, lo, doneAt, busyCnt, dz); // leaves Hi/Lo nonzero
    @(negedge Clk);
    Start = 1'b1; A = 32'd100; B = 32'd7;
    for (int k = 0; k < 15; k++) begin @(negedge Clk); Start = 1'b0; end
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    tests++; if (Busy !== 1'b0 || Done !== 1'b0 || Hi !== 32'd0 || Lo !== 32'd0) begin fails++; $display("FAIL mid_reset: got busy=%b done=%b hi=%h lo=%h expected 0 0 0 0", Busy, Done, Hi, Lo); end
    sawDone = 0;
    for (int k = 0; k < 40; k++) begin @(negedge Clk); if (Done || Busy) sawDone++; end
    tests++; if (sawDone !== 0) begin fails++; $display("FAIL mid_reset_quiet: got %0d cycles active expected 0", sawDone); end
    runOp(32'd20, 32'd6, 1'b0, -1, hi, lo, doneAt, busyCnt, dz);
    tests++; if (doneAt !== 33 || lo !== 32'd3 || hi !== 32'd2) begin fails++; $display("FAIL post_reset: got at=%0d lo=%h hi=%h expected 33 3 2", doneAt, lo, hi); end
    lastHi = 32'd2; lastLo = 32'd3;
  endtask

  task automatic test_random;
    logic [31:0] a, b, hi, lo, eq, er; int doneAt, busyCnt; logic dz; int mode;
    for (int i = 0; i < 40; i++) begin
      mode = int'($urandom_range(0, 5));
      a = $urandom; b = $urandom;
      case (mode)
        0: begin a = 32'($urandom_range(0, 200)) - 32'd100; b = 32'($urandom_range(0, 20)) - 32'd10; end
        1: b = 32'd0;
        2: b = ($urandom_range(0, 1) != 0) ? 32'd1 : 32'hFFFFFFFF;
        3: a = 32'h80000000;
        4: b = {{16{b[15]}}, b[15:0]};
        default: ;
      endcase
      runOp(a, b, 1'b0, -1, hi, lo, doneAt, busyCnt, dz);
      if (b == 32'd0) begin
        tests++;
        if (doneAt !== 0 || dz !== 1'b1 || hi !== lastHi || lo !== lastLo) begin
          fails++;
          $display("FAIL rand_dz_%0d: got at=%0d dz=%b hi=%h lo=%h expected 0 1 %h %h", i, doneAt, dz, hi, lo, lastHi, lastLo);
        end
      end else begin
        refDiv(a, b, eq, er);
        tests++;
        if (doneAt !== 33 || dz !== 1'b0 || lo !== eq || hi !== er) begin
          fails++;
          $display("FAIL rand_%0d a=%h b=%h: got at=%0d dz=%b lo=%h hi=%h expected 33 0 %h %h", i, a, b, doneAt, dz, lo, hi, eq, er);
        end
        lastHi = er; lastLo = eq;
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_divzero;
    test_signs;
    test_back_to_back;
    test_mid_reset;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
